rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single-port, 1-cycle-registered image ROM between N pixel-drawing requesters, e.g. background, ball and two player sprites.
- Round-robin arbitration with bounded bursts, so one requester can stream a run of pixels back-to-back.
- Drives the ROM address and returns ROM data to the owning requester with a one-hot valid.
- Sits between the draw units and image_rom in the VGA pipeline.

Parameters:
N_REQ, 3, number of requesters (2..8)
ADDR_W, 20, ROM address width ({y[9:0], x[9:0]})
DATA_W, 12, ROM data width (4-bit R,G,B)
BURST, 16, max beats granted per ownership before forced re-arbitration (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  N_REQ  per-requester request; held high while it has beats to issue
addr_in  in  N_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W]
gnt  out  N_REQ  one-hot beat accept; a beat transfers on a rising edge with req[i]&gnt[i]
rom_addr  out  ADDR_W  address to image_rom, registered
rom_rgb  in  DATA_W  image_rom output, valid one cycle after rom_addr
rdata  out  DATA_W  returned pixel data, registered
rvalid  out  N_REQ  one-hot: rdata belongs to requester i this cycle

Behaviour:
- Reset (async, any time): state=IDLE, rr_ptr=0, owner=0, cnt=0, rom_addr=0, pipeline valid/tag=0, rdata=0, rvalid=0.
  - gnt is 0 during reset.
  - In-flight reads are discarded; no rvalid is produced after reset releases.
- FSM states:
  - IDLE: gnt=0. If any req, select the first i with req[i] searching from rr_ptr upward, wrapping modulo N_REQ. Next state is BUSY, owner=i, cnt=0. If no req, stay in IDLE.
  - BUSY: gnt[owner]=req[owner], all other gnt bits 0. gnt is combinational from state/owner and req.
- Beat accept in BUSY (req[owner]=1):
  - rom_addr <= addr_in[owner].
  - v1 <= 1, t1 <= owner.
  - cnt <= cnt+1.
- Release from BUSY:
  - Condition (a): accept with cnt==BURST-1. Go to IDLE and set rr_ptr <= (owner+1) mod N_REQ.
  - Condition (b): req[owner]==0. No accept. Go to IDLE and set rr_ptr <= (owner+1) mod N_REQ.
  - One idle bubble cycle occurs per ownership change.
- Non-accept cycles: v1 <= 0; rom_addr holds its value.
- Return path, with accept at edge E0:
  - ROM samples rom_addr at E1.
  - At E2: rdata <= rom_rgb, rvalid <= v1_delayed ? onehot(t1_delayed) : 0. The v1/t1 pair is delayed one stage to align with ROM latency.
  - Result: rvalid is high in the cycle following E2, i.e. 2 cycles after the accept edge.
  - Responses are strictly in issue order, at most one per cycle, and exactly one rvalid per accepted beat.
- rvalid is never more than one bit high. rdata holds its value when rvalid=0.
- The requester must keep addr_in stable while req is high and gnt is low. The address is sampled only on an accepted beat.
- Requester behaviour while not owner: req rising on a non-owner during BUSY has no effect until the next IDLE.
- BURST=1: every beat re-arbitrates, giving strict round-robin with a bubble between beats.
- Requester index wrap: rr_ptr after owner N_REQ-1 is 0.

Test Plan:
- Single requester: req[0] continuously, addr 0x00000..0x0000F, BURST=16 -> 16 consecutive gnt[0] beats; rvalid[0] 2 cycles after each accept with rdata = rom[addr]; then one IDLE cycle; regrant of 0.
- Contention: req[0..2] all high, BURST=4 -> grant order 0 (4 beats), bubble, 1 (4 beats), bubble, 2 (4 beats), bubble, 0; rvalid tags match issue order.
- Early drop: owner 1 deasserts req after 3 beats -> FSM to IDLE, rr_ptr=2; the 3 returns are still delivered to rvalid[1].
- Wrap: only req[2] and req[0] high, rr_ptr=2 -> 2 served first, then 0.
- Reset mid-burst: assert rst with 2 reads in flight -> all outputs 0 immediately; no rvalid after release; the first grant after reset goes to the lowest active req index.
- Idle/hold: no req for 10 cycles -> gnt=0, rvalid=0; rom_addr and rdata unchanged.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Bundle shared by the draw units, the arbiter and image_rom.
// The master side drives requests, addresses and the ROM data.
// The slave side is the arbiter.
interface rom_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 12
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr_in;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_rgb;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        rvalid;

  modport master (
    output req, addr_in, rom_rgb,
    input  gnt, rom_addr, rdata, rvalid
  );

  modport slave (
    input  req, addr_in, rom_rgb,
    output gnt, rom_addr, rdata, rvalid
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter that shares the single-port registered image ROM between
// several pixel requesters. Each owner may stream up to BURST beats before it
// must give up the ROM. Read data comes back two cycles after the accept, with
// a one-hot tag that names the requester.
module rom_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned BURST  = 16
) (
  input logic           clk,
  input logic           rst,
  rom_arbiter_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam int unsigned CntW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]     owner_q, owner_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                v1_q, v1_d, v2_q, v2_d;
  logic [PtrW-1:0]     t1_q, t1_d, t2_q, t2_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_REQ-1:0]    rvalid_q, rvalid_d;

  logic                accept;
  logic                found;
  logic [PtrW-1:0]     pick;
  logic [PtrW-1:0]     owner_next;

  // (base + k) mod N_REQ, with both operands known to be below N_REQ
  function automatic logic [PtrW-1:0] wrap_idx(input logic [PtrW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PtrW'(s);
  endfunction

  assign accept     = (state_q == StBusy) && bus.req[owner_q];
  assign owner_next = (owner_q == PtrW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // First active request at or after rr_ptr, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && bus.req[wrap_idx(rr_ptr_q, k)]) begin
        found = 1'b1;
        pick  = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  // Grant mirrors the owner's request, so a beat is accepted in the same cycle
  always_comb begin
    bus.gnt = '0;
    if (state_q == StBusy) bus.gnt[owner_q] = bus.req[owner_q];
  end

  // Ownership FSM, burst counting and address issue
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    v1_d       = 1'b0;
    t1_d       = t1_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StBusy;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (accept) begin
          rom_addr_d = bus.addr_in[owner_q*ADDR_W +: ADDR_W];
          v1_d       = 1'b1;
          t1_d       = owner_q;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CntW'(BURST - 1)) begin
            state_d  = StIdle;
            rr_ptr_d = owner_next;
          end
        end else begin
          // Owner ran out of beats early
          state_d  = StIdle;
          rr_ptr_d = owner_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Return path: the tag is delayed one extra stage to line up with the ROM latency
  always_comb begin
    v2_d     = v1_q;
    t2_d     = t1_q;
    rdata_d  = v2_q ? bus.rom_rgb : rdata_q;
    rvalid_d = '0;
    if (v2_q) rvalid_d[t2_q] = 1'b1;
  end

  // State registers; reset drops any reads still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      v1_q       <= 1'b0;
      t1_q       <= '0;
      v2_q       <= 1'b0;
      t2_q       <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      v1_q       <= v1_d;
      t1_q       <= t1_d;
      v2_q       <= v2_d;
      t2_q       <= t2_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed phases followed by random traffic. A
// transaction-level model predicts the grants, and a queue of expected
// responses predicts the returned pixels.
module tb_rom_arbiter;
  localparam int unsigned N     = 3;
  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 12;
  localparam int unsigned BURST = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Image ROM contents: an arbitrary function of the address
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] x);
    return x[11:0] ^ x[19:8] ^ 12'h5a3;
  endfunction

  // Image ROM with a one-cycle registered read
  always @(posedge clk) bus.rom_rgb <= rom_f(bus.rom_addr);

  typedef struct {
    int            due;
    int            tag;
    logic [DW-1:0] data;
  } resp_t;

  resp_t          q[$];
  int             m_owner = -1;
  int             m_cnt   = 0;
  int             m_ptr   = 0;
  logic [AW-1:0]  m_rom_addr = '0;
  logic [DW-1:0]  m_rdata    = '0;
  int             n_edge  = 0;
  int             n_cmp   = 0;
  int             n_err   = 0;
  logic [N-1:0]   req_v   = '0;
  logic [AW-1:0]  a [N];
  int             acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one rising edge to the model
  task automatic model_edge();
    acc = -1;
    if (rst) return;
    n_edge++;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req_v[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
        end
      end
    end else if (req_v[m_owner]) begin
      acc = m_owner;
      q.push_back('{n_edge + 2, m_owner, rom_f(a[m_owner])});
      m_rom_addr = a[m_owner];
      m_cnt++;
      if (m_cnt == BURST) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  // Drive the inputs, check gnt, take one edge, then check the registered outputs
  task automatic cycle();
    logic [N-1:0] eg;
    logic [N-1:0] ev;
    bus.req = req_v;
    for (int i = 0; i < N; i++) bus.addr_in[i*AW +: AW] = a[i];
    #1;
    eg = '0;
    if (m_owner >= 0 && !rst) eg[m_owner] = req_v[m_owner];
    chk("gnt", 32'(bus.gnt), 32'(eg));
    @(posedge clk);
    model_edge();
    #1;
    ev = '0;
    if (!rst && q.size() > 0 && q[0].due == n_edge) begin
      ev[q[0].tag] = 1'b1;
      m_rdata      = q[0].data;
      void'(q.pop_front());
    end
    chk("rvalid", 32'(bus.rvalid), 32'(ev));
    chk("rdata", 32'(bus.rdata), 32'(m_rdata));
    chk("rom_addr", 32'(bus.rom_addr), 32'(m_rom_addr));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'h0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'h0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) a[i] = '0;
    bus.req     = '0;
    bus.addr_in = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single requester streaming sequential addresses
    req_v = 3'b001;
    for (int c = 0; c < 26; c++) begin
      cycle();
      if (acc >= 0) a[acc] = a[acc] + 1'b1;
    end

    // Nobody requesting: outputs must hold
    req_v = '0;
    for (int c = 0; c < 10; c++) cycle();

    // Everyone contending
    req_v = 3'b111;
    for (int c = 0; c < 24; c++) begin
      cycle();
      if (acc >= 0) a[acc] = AW'($urandom);
    end

    // Owner 1 drops after three beats, then only 2 and 0 request
    req_v = 3'b010;
    for (int c = 0; c < 30 && !(m_owner == 1 && m_cnt == 3); c++) begin
      cycle();
      if (acc >= 0) a[acc] = AW'($urandom);
    end
    req_v = 3'b101;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (acc >= 0) a[acc] = AW'($urandom);
    end

    // Reset while reads are in flight
    req_v = 3'b111;
    for (int c = 0; c < 20 && q.size() < 2; c++) begin
      cycle();
      if (acc >= 0) a[acc] = AW'($urandom);
    end
    #2 rst = 1'b1;
    #1 check_zero("midreset");
    q.delete();
    m_owner    = -1;
    m_cnt      = 0;
    m_ptr      = 0;
    m_rom_addr = '0;
    m_rdata    = '0;
    cycle();
    cycle();
    rst   = 1'b0;
    req_v = 3'b110;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (acc >= 0) a[acc] = AW'($urandom);
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) req_v[i] = ~req_v[i];
      cycle();
      if (acc >= 0) a[acc] = AW'($urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
